// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcode and FSM
// encodings, the default data width and a signedness helper.
package muldiv_hilo_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_DIV    = 3'd2,
    ST_FIX    = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Request/response bundle between the pipeline (master) and the HI/LO unit (slave).
interface muldiv_hilo_unit_if
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush,
    input  req_ready, busy, done, hi_out, lo_out
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush,
    output req_ready, busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_hilo_unit_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// Build option DIV_EARLY_EXIT_EN: finish in one cycle when dividend < divisor.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            last_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic            early_q;
  logic            early;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

`ifdef DIV_EARLY_EXIT_EN
  assign early = (divisor_i != '0) && (dividend_i < divisor_i);
`else
  assign early = 1'b0;
`endif

  // quot_q doubles as the dividend shift register; its MSB feeds the remainder.
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      early_q <= 1'b0;
    end else if (start_i) begin
      dvs_q   <= divisor_i;
      early_q <= early;
      if (early) begin
        quot_q  <= '0;
        rem_q   <= dividend_i;
        count_q <= CW'(1);
      end else begin
        quot_q  <= dividend_i;
        rem_q   <= '0;
        count_q <= CW'(XLEN);
      end
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
      if (!early_q) begin
        if (!diff[XLEN]) begin
          rem_q  <= diff[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q  <= shifted[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign busy_o      = (count_q != '0);
  assign last_o      = (count_q == CW'(1));
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// MIPS-style HI/LO multiply/divide unit: multi-cycle MULT/DIV plus MTHI/MTLO.
// Optional build macro DIV_EARLY_EXIT_EN shortens small-dividend divides.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_hilo_unit_if.slave    bus
);
  localparam int CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  state_e            state_q, state_d;
  op_e               op_q;
  op_e               req_op;
  logic [XLEN-1:0]   a_q, b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   res_hi_q, res_lo_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              accept;
  logic              req_ready, busy, done, commit_en, div_start;
  logic              div_busy, div_last;
  logic [XLEN-1:0]   div_quot, div_rem;
  logic [XLEN-1:0]   dvd_mag, dvs_mag;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign req_op = op_e'(bus.req_op);
  assign accept = bus.req_valid && (state_q == ST_IDLE) && !bus.flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: state_d = ST_MUL;
            OP_DIV,  OP_DIVU:  state_d = ST_DIV;
            OP_MTHI, OP_MTLO:  state_d = ST_COMMIT;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_MUL:    if (cnt_q == CNT_W'(MUL_STAGES - 1)) state_d = ST_COMMIT;
      ST_DIV:    if (div_last || !div_busy) state_d = ST_FIX;
      ST_FIX:    state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    commit_en = (state_q == ST_COMMIT) && !bus.flush;
    done      = commit_en;
    div_start = accept && ((req_op == OP_DIV) || (req_op == OP_DIVU));
  end

  // Divider works on magnitudes taken straight from the request at accept.
  always_comb begin
    dvd_mag = bus.req_src1;
    dvs_mag = bus.req_src2;
    if (op_is_signed(req_op) && bus.req_src1[XLEN-1]) dvd_mag = -bus.req_src1;
    if (op_is_signed(req_op) && bus.req_src2[XLEN-1]) dvs_mag = -bus.req_src2;
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .busy_o      (div_busy),
    .last_o      (div_last),
    .quotient_o  (div_quot),
    .remainder_o (div_rem)
  );

  // Low 2*XLEN bits of a product of sign/zero-extended operands are exact.
  assign mul_a   = {{XLEN{op_is_signed(op_q) & a_q[XLEN-1]}}, a_q};
  assign mul_b   = {{XLEN{op_is_signed(op_q) & b_q[XLEN-1]}}, b_q};
  assign product = mul_a * mul_b;

  always_comb begin
    neg_a  = (op_q == OP_DIV) && a_q[XLEN-1];
    neg_b  = (op_q == OP_DIV) && b_q[XLEN-1];
    fix_lo = (neg_a ^ neg_b) ? -div_quot : div_quot;
    fix_hi = neg_a ? -div_rem : div_rem;
    if (b_q == '0) begin
      fix_lo = '1;
      fix_hi = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        a_q   <= bus.req_src1;
        b_q   <= bus.req_src2;
        cnt_q <= '0;
      end
      if (state_q == ST_MUL) begin
        cnt_q    <= cnt_q + CNT_W'(1);
        res_hi_q <= product[2*XLEN-1:XLEN];
        res_lo_q <= product[XLEN-1:0];
      end
      if (state_q == ST_FIX) begin
        res_hi_q <= fix_hi;
        res_lo_q <= fix_lo;
      end
    end
  end

  // Architectural HI/LO only move on a committing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit_en) begin
      case (op_q)
        OP_MTHI: hi_q <= a_q;
        OP_MTLO: lo_q <= a_q;
        default: begin
          hi_q <= res_hi_q;
          lo_q <= res_lo_q;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;

endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand, HI and LO width (even, >=8).
REQ-002 Parameter MUL_STAGES, default 2, SHALL set multiply latency in cycles (>=1).
REQ-003 Port clk, input, 1: clock; reset, input, 1: reset, synchronous, active-high.
REQ-004 Port req_valid, input, 1: an operation is offered.
REQ-005 Port req_ready, output, 1: the unit accepts an operation this cycle.
REQ-006 Port req_op, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
REQ-007 Port req_src1, input, XLEN: rs value (dividend, multiplicand, or MTHI/MTLO data).
REQ-008 Port req_src2, input, XLEN: rt value (divisor or multiplier).
REQ-009 Port flush, input, 1: exception or eret cancel.
REQ-010 Port busy, output, 1: an operation is in flight.
REQ-011 Port done, output, 1: one-cycle pulse when HI/LO commit.
REQ-012 Ports hi_out and lo_out, output, XLEN: architectural HI and LO registers.

Function
REQ-013 Accept condition SHALL be req_valid & req_ready & ~flush; req_ready SHALL be 1 only in IDLE.
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX and COMMIT.
REQ-015 On accept, IDLE SHALL go to MUL for op 0/1, DIV for op 2/3, and COMMIT for op 4/5; reserved ops SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-016 MUL SHALL hold for MUL_STAGES cycles, then go to COMMIT.
REQ-017 MULT/MULTU SHALL give a 2*XLEN product, {HI,LO} = product, signed or unsigned per op.
REQ-018 DIV SHALL run restoring radix-2 on operand magnitudes for XLEN cycles, then go to FIX.
REQ-019 FIX SHALL take one cycle: quotient negated if the operand signs differ (signed op only), remainder takes the dividend's sign; then go to COMMIT.
REQ-020 Divide results SHALL be LO = quotient, HI = remainder.
REQ-021 Divisor 0 SHALL give LO = all ones and HI = dividend, with no exception.
REQ-022 Signed most-negative / -1 SHALL give LO = most-negative and HI = 0.
REQ-023 MTHI SHALL write only HI and MTLO SHALL write only LO, each with req_src1.
REQ-024 COMMIT SHALL last one cycle: HI/LO are written, done=1, then the FSM goes to IDLE.
REQ-025 Total accept-to-done latency SHALL be MUL_STAGES+1 for multiply, XLEN+2 for divide, and 1 for MTHI/MTLO.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 Operands SHALL be captured at accept; later changes on the req_* inputs SHALL have no effect.
REQ-028 flush in any non-IDLE state, COMMIT included, SHALL go to IDLE next cycle with no HI/LO write and no done.
REQ-029 flush together with req_valid in IDLE SHALL drop the request.
REQ-030 hi_out/lo_out SHALL change only on a COMMIT edge.

Reset
REQ-031 Reset SHALL force IDLE with HI=0, LO=0, done=0, busy=0 and req_ready=1 on the next edge.
REQ-032 Reset mid-operation SHALL discard the operation with no commit.
REQ-033 Reset SHALL take priority over flush and accept.

Configuration
REQ-034 With DIV_EARLY_EXIT_EN defined, a divide with |dividend| < |divisor| and divisor != 0 SHALL go from DIV to FIX after one cycle (latency 3), quotient 0, remainder = dividend.
REQ-035 Without DIV_EARLY_EXIT_EN, every divide SHALL take XLEN+2 cycles; results SHALL be identical in both builds.

Structure
REQ-036 Shared package SHALL hold the req_op encodings, the FSM state encoding, and the XLEN default.
REQ-037 The restoring divider datapath SHALL be sub-module div_iter (start, busy, quotient and remainder magnitudes); multiply, FIX and HI/LO logic SHALL stay in the top module.

Verification
REQ-038 MULT 0xFFFFFFFE x 0x00000003 -> done at cycle 3; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-039 DIV 0xFFFFFFF9 (-7) / 2 -> done at cycle 34; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-040 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-041 DIVU 100/7 with flush at cycle 10 -> no done; HI/LO unchanged; req_ready=1 at cycle 11.
REQ-042 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> done each at cycle 1; hi_out/lo_out match; reset at cycle 5 of a MULTU -> HI=LO=0, no done.
REQ-043 With DIV_EARLY_EXIT_EN, DIVU 3/10 -> done at cycle 3; LO=0, HI=3.
